gray_code_counter: RTL and testbench
====================================

Name: gray_code_counter

Overview:
Parametrised synchronous Gray-code counter. It is the sequential successor to the combinational binary-to-Gray converter.
- Holds a binary count and presents both the binary value and the Gray-coded value from registers.
- Supports up/down counting, enable, and synchronous load of either a binary or a Gray-coded value.
- Supports a wrap or saturate mode at the boundaries.
- Intended for multi-bit pointers and position counters that cross clock domains or drive glitch-sensitive decoders.

Parameters:
N, 8, counter width in bits (N >= 2)
WRAP, 1, 1 = wrap at boundaries; 0 = saturate (hold) at boundaries
RESET_VALUE, 0, binary value loaded on reset (must be < 2**N)

Ports:
Clk  input  1  clock, all state updates on rising edge
Rst  input  1  synchronous reset, active-high
En  input  1  count enable
Up  input  1  direction: 1 = increment, 0 = decrement
Load  input  1  synchronous load strobe
LoadGray  input  1  1 = LoadValue is Gray-coded; 0 = LoadValue is binary
LoadValue  input  N  value to load
BinCount  output  N  registered binary count
GrayCount  output  N  registered Gray count, always equal to BinCount ^ (BinCount >> 1)
TerminalCount  output  1  combinational: (Up && BinCount == 2**N-1) || (!Up && BinCount == 0)
Wrapped  output  1  registered one-cycle pulse: the previous edge performed a wrap-around

Behaviour:
- Clock and reset: one clock domain (Clk). Reset is synchronous and active-high (Rst).
- Priority per rising edge: Rst > Load > En. With none active, hold all state; Wrapped goes to 0.
- Reset:
  - BinCount = RESET_VALUE; GrayCount = RESET_VALUE ^ (RESET_VALUE >> 1); Wrapped = 0.
  - Reset asserted mid-count takes effect at the next edge regardless of Load/En.
- Load (Rst = 0, Load = 1; En ignored):
  - LoadGray = 0: next BinCount = LoadValue.
  - LoadGray = 1: next BinCount = Gray-to-binary of LoadValue, where b[N-1] = g[N-1] and b[i] = b[i+1] ^ g[i] for i < N-1.
  - Wrapped = 0 after a load.
- Count (Rst = 0, Load = 0, En = 1):
  - Up = 1, BinCount < 2**N-1: BinCount + 1.
  - Up = 0, BinCount > 0: BinCount - 1.
  - Boundary, WRAP = 1: all-ones wraps to 0 (up), 0 wraps to all-ones (down); Wrapped = 1 for exactly one cycle.
  - Boundary, WRAP = 0: count holds; Wrapped = 0.
- En = 0 and Load = 0: hold; Wrapped = 0.
- Latency:
  - New BinCount and GrayCount are visible one cycle after the controlling edge.
  - Both outputs update on the same edge; there is never a cycle where they disagree.
- GrayCount source:
  - Registered from the next-state binary value, i.e. computed before the register, not after it.
  - Glitch-free output: consecutive counted values differ in exactly one GrayCount bit, including across the wrap.
- TerminalCount:
  - Decodes registered BinCount and the live Up input; no extra latency.
  - Valid in both WRAP modes.
- Arithmetic:
  - All counting is modulo 2**N in wrap mode.
  - No intermediate value wider than N+1 bits.
- Direction change mid-count is legal; it takes effect on the next enabled edge.

Test Plan:
- N = 8, WRAP = 1, Rst then En = 1, Up = 1 for 256 cycles -> BinCount 0..255..0; every step changes exactly one GrayCount bit; at 255, GrayCount = 0x80 and TerminalCount = 1; the cycle after 255->0, Wrapped = 1 for one cycle only.
- N = 8, WRAP = 1, from 0 with En = 1, Up = 0 -> next BinCount = 0xFF, GrayCount = 0x80, Wrapped = 1; TerminalCount = 1 while at 0 with Up = 0.
- N = 4, WRAP = 0, count up 20 cycles from 0 -> BinCount holds at 15, GrayCount = 0x8, Wrapped never asserted; then Up = 0 for 1 cycle -> BinCount = 14, GrayCount = 0x9.
- Load = 1, LoadGray = 1, LoadValue = 0xC0 with En = 1 (same cycle) -> BinCount = 0x80, GrayCount = 0xC0 (load wins over count); next enabled up edge -> 0x81 / 0xC1.
- Load = 1, LoadGray = 0, LoadValue = 0x3A -> BinCount = 0x3A, GrayCount = 0x27.
- Count to 0x55, then assert Rst together with Load = 1 and En = 1 (RESET_VALUE = 0) -> BinCount = 0, GrayCount = 0, Wrapped = 0 at the next edge.

Source files
------------

// File: rtl/gray_code_counter.sv
// Parametrised synchronous Gray-code counter with up/down, enable, binary or Gray load,
// and wrap/saturate boundary handling. Binary and Gray values are both registered.
module gray_code_counter #(
  parameter int          N           = 8,
  parameter int          WRAP        = 1,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         En,
  input  logic         Up,
  input  logic         Load,
  input  logic         LoadGray,
  input  logic [N-1:0] LoadValue,
  output logic [N-1:0] BinCount,
  output logic [N-1:0] GrayCount,
  output logic         TerminalCount,
  output logic         Wrapped
);

  localparam logic [N-1:0] ALL_ONES  = {N{1'b1}};
  localparam logic [N-1:0] ZERO      = {N{1'b0}};
  localparam logic [N-1:0] ONE       = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] RESET_BIN = N'(RESET_VALUE);
  localparam logic         WRAP_EN   = (WRAP != 0);

  function automatic logic [N-1:0] bin_to_gray(input logic [N-1:0] b);
    bin_to_gray = b ^ (b >> 1);
  endfunction

  function automatic logic [N-1:0] gray_to_bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    gray_to_bin = b;
  endfunction

  logic [N-1:0] bin_r;
  logic [N-1:0] gray_r;
  logic         wrapped_r;
  logic [N-1:0] next_bin_s;
  logic         next_wrap_s;
  logic         at_max_s;
  logic         at_zero_s;

  assign at_max_s  = (bin_r == ALL_ONES);
  assign at_zero_s = (bin_r == ZERO);

  // Next binary value and wrap flag; load beats count, reset is applied in the register.
  always_comb begin
    next_bin_s  = bin_r;
    next_wrap_s = 1'b0;
    if (Load) begin
      if (LoadGray) begin
        next_bin_s = gray_to_bin(LoadValue);
      end else begin
        next_bin_s = LoadValue;
      end
    end else if (En) begin
      if (Up) begin
        if (!at_max_s) begin
          next_bin_s = bin_r + ONE;
        end else if (WRAP_EN) begin
          next_bin_s  = ZERO;
          next_wrap_s = 1'b1;
        end else begin
          next_bin_s = bin_r;
        end
      end else begin
        if (!at_zero_s) begin
          next_bin_s = bin_r - ONE;
        end else if (WRAP_EN) begin
          next_bin_s  = ALL_ONES;
          next_wrap_s = 1'b1;
        end else begin
          next_bin_s = bin_r;
        end
      end
    end else begin
      next_bin_s  = bin_r;
      next_wrap_s = 1'b0;
    end
  end

  // Gray is encoded from the next binary value so both registers always agree.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      bin_r     <= RESET_BIN;
      gray_r    <= bin_to_gray(RESET_BIN);
      wrapped_r <= 1'b0;
    end else begin
      bin_r     <= next_bin_s;
      gray_r    <= bin_to_gray(next_bin_s);
      wrapped_r <= next_wrap_s;
    end
  end

  assign BinCount      = bin_r;
  assign GrayCount     = gray_r;
  assign Wrapped       = wrapped_r;
  assign TerminalCount = (Up && at_max_s) || (!Up && at_zero_s);

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed self-checking bench: an 8-bit wrapping counter and a 4-bit saturating counter.
module tb_gray_code_counter;

  logic       Clk;
  logic       Rst, En, Up, Load, LoadGray;
  logic [7:0] LoadValue, BinCount, GrayCount;
  logic       TerminalCount, Wrapped;

  logic       rst4, en4, up4, load4, load_gray4;
  logic [3:0] load_value4, bin4, gray4;
  logic       tc4, wrapped4;

  int vectors;
  int miscompares;

  gray_code_counter #(.N(8), .WRAP(1), .RESET_VALUE(0)) dut8 (
    .Clk(Clk), .Rst(Rst), .En(En), .Up(Up), .Load(Load), .LoadGray(LoadGray),
    .LoadValue(LoadValue), .BinCount(BinCount), .GrayCount(GrayCount),
    .TerminalCount(TerminalCount), .Wrapped(Wrapped)
  );

  gray_code_counter #(.N(4), .WRAP(0), .RESET_VALUE(0)) dut4 (
    .Clk(Clk), .Rst(rst4), .En(en4), .Up(up4), .Load(load4), .LoadGray(load_gray4),
    .LoadValue(load_value4), .BinCount(bin4), .GrayCount(gray4),
    .TerminalCount(tc4), .Wrapped(wrapped4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; En = 1'b1; Up = 1'b1; Load = 1'b0; LoadGray = 1'b0; LoadValue = 8'h00;
    step();
    Rst = 1'b0; En = 1'b0;
    #1;
    vectors++;
    if (BinCount !== 8'h00) begin miscompares++; $display("FAIL reset_bin got %h want 00", BinCount); end
    vectors++;
    if (GrayCount !== 8'h00) begin miscompares++; $display("FAIL reset_gray got %h want 00", GrayCount); end
    vectors++;
    if (Wrapped !== 1'b0) begin miscompares++; $display("FAIL reset_wrapped got %b want 0", Wrapped); end
    vectors++;
    if (TerminalCount !== 1'b0) begin miscompares++; $display("FAIL reset_tc_up got %b want 0", TerminalCount); end
    step();
    vectors++;
    if (BinCount !== 8'h00) begin miscompares++; $display("FAIL hold_after_reset got %h want 00", BinCount); end
  endtask

  task automatic test_up_wrap();
    logic [7:0] prev_gray;
    logic [7:0] exp_bin;
    int bad_gray, bad_step, bad_bin, bad_wrap;
    bad_gray = 0; bad_step = 0; bad_bin = 0; bad_wrap = 0;
    prev_gray = GrayCount;
    En = 1'b1; Up = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      step();
      exp_bin = 8'(i);
      if (BinCount !== exp_bin) bad_bin++;
      if (GrayCount !== (exp_bin ^ (exp_bin >> 1))) bad_gray++;
      if ($countones(prev_gray ^ GrayCount) != 1) bad_step++;
      if (Wrapped !== (i == 256)) bad_wrap++;
      prev_gray = GrayCount;
      if (i == 255) begin
        vectors++;
        if (GrayCount !== 8'h80) begin miscompares++; $display("FAIL gray_at_ff got %h want 80", GrayCount); end
        vectors++;
        if (TerminalCount !== 1'b1) begin miscompares++; $display("FAIL tc_at_ff got %b want 1", TerminalCount); end
      end
    end
    vectors++;
    if (bad_bin != 0) begin miscompares++; $display("FAIL up_seq_bin bad steps %0d want 0", bad_bin); end
    vectors++;
    if (bad_gray != 0) begin miscompares++; $display("FAIL up_seq_gray bad steps %0d want 0", bad_gray); end
    vectors++;
    if (bad_step != 0) begin miscompares++; $display("FAIL gray_one_bit bad steps %0d want 0", bad_step); end
    vectors++;
    if (bad_wrap != 0) begin miscompares++; $display("FAIL up_wrap_pulse bad steps %0d want 0", bad_wrap); end
    step();
    vectors++;
    if (Wrapped !== 1'b0) begin miscompares++; $display("FAIL wrap_one_cycle got %b want 0", Wrapped); end
    vectors++;
    if (BinCount !== 8'h01) begin miscompares++; $display("FAIL after_wrap_bin got %h want 01", BinCount); end
    En = 1'b0;
  endtask

  task automatic test_down_wrap();
    Load = 1'b1; LoadGray = 1'b0; LoadValue = 8'h00;
    step();
    Load = 1'b0; Up = 1'b0;
    #1;
    vectors++;
    if (TerminalCount !== 1'b1) begin miscompares++; $display("FAIL tc_at_zero_down got %b want 1", TerminalCount); end
    En = 1'b1;
    step();
    vectors++;
    if (BinCount !== 8'hFF) begin miscompares++; $display("FAIL down_wrap_bin got %h want ff", BinCount); end
    vectors++;
    if (GrayCount !== 8'h80) begin miscompares++; $display("FAIL down_wrap_gray got %h want 80", GrayCount); end
    vectors++;
    if (Wrapped !== 1'b1) begin miscompares++; $display("FAIL down_wrap_pulse got %b want 1", Wrapped); end
    step();
    vectors++;
    if (BinCount !== 8'hFE) begin miscompares++; $display("FAIL down_step_bin got %h want fe", BinCount); end
    vectors++;
    if (Wrapped !== 1'b0) begin miscompares++; $display("FAIL down_wrap_clear got %b want 0", Wrapped); end
    En = 1'b0;
    step();
    vectors++;
    if (BinCount !== 8'hFE) begin miscompares++; $display("FAIL hold_disabled got %h want fe", BinCount); end
  endtask

  task automatic test_saturate();
    int wrap_seen;
    wrap_seen = 0;
    rst4 = 1'b1; en4 = 1'b0; up4 = 1'b1; load4 = 1'b0; load_gray4 = 1'b0; load_value4 = 4'h0;
    step();
    rst4 = 1'b0; en4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (wrapped4 !== 1'b0) wrap_seen++;
    end
    vectors++;
    if (bin4 !== 4'hF) begin miscompares++; $display("FAIL sat_bin got %h want f", bin4); end
    vectors++;
    if (gray4 !== 4'h8) begin miscompares++; $display("FAIL sat_gray got %h want 8", gray4); end
    vectors++;
    if (wrap_seen != 0) begin miscompares++; $display("FAIL sat_no_wrap got %0d pulses want 0", wrap_seen); end
    vectors++;
    if (tc4 !== 1'b1) begin miscompares++; $display("FAIL sat_tc got %b want 1", tc4); end
    up4 = 1'b0;
    step();
    vectors++;
    if (bin4 !== 4'hE) begin miscompares++; $display("FAIL sat_down_bin got %h want e", bin4); end
    vectors++;
    if (gray4 !== 4'h9) begin miscompares++; $display("FAIL sat_down_gray got %h want 9", gray4); end
    en4 = 1'b0;
  endtask

  task automatic test_load_gray();
    Load = 1'b1; LoadGray = 1'b1; LoadValue = 8'hC0; En = 1'b1; Up = 1'b1;
    step();
    vectors++;
    if (BinCount !== 8'h80) begin miscompares++; $display("FAIL load_gray_bin got %h want 80", BinCount); end
    vectors++;
    if (GrayCount !== 8'hC0) begin miscompares++; $display("FAIL load_gray_gray got %h want c0", GrayCount); end
    Load = 1'b0;
    step();
    vectors++;
    if (BinCount !== 8'h81) begin miscompares++; $display("FAIL load_gray_next_bin got %h want 81", BinCount); end
    vectors++;
    if (GrayCount !== 8'hC1) begin miscompares++; $display("FAIL load_gray_next_gray got %h want c1", GrayCount); end
    Load = 1'b1; LoadValue = 8'h27; En = 1'b0;
    step();
    vectors++;
    if (BinCount !== 8'h3A) begin miscompares++; $display("FAIL load_gray27_bin got %h want 3a", BinCount); end
    Load = 1'b0;
  endtask

  task automatic test_load_bin();
    Load = 1'b1; LoadGray = 1'b0; LoadValue = 8'h3A; En = 1'b0;
    step();
    Load = 1'b0;
    vectors++;
    if (BinCount !== 8'h3A) begin miscompares++; $display("FAIL load_bin_bin got %h want 3a", BinCount); end
    vectors++;
    if (GrayCount !== 8'h27) begin miscompares++; $display("FAIL load_bin_gray got %h want 27", GrayCount); end
    vectors++;
    if (Wrapped !== 1'b0) begin miscompares++; $display("FAIL load_bin_wrapped got %b want 0", Wrapped); end
  endtask

  task automatic test_reset_priority();
    Load = 1'b1; LoadGray = 1'b0; LoadValue = 8'h54;
    step();
    Load = 1'b0; En = 1'b1; Up = 1'b1;
    step();
    vectors++;
    if (BinCount !== 8'h55) begin miscompares++; $display("FAIL pre_reset_bin got %h want 55", BinCount); end
    vectors++;
    if (GrayCount !== 8'h7F) begin miscompares++; $display("FAIL pre_reset_gray got %h want 7f", GrayCount); end
    Rst = 1'b1; Load = 1'b1; LoadValue = 8'hAA;
    step();
    Rst = 1'b0; Load = 1'b0; En = 1'b0;
    vectors++;
    if (BinCount !== 8'h00) begin miscompares++; $display("FAIL rst_prio_bin got %h want 00", BinCount); end
    vectors++;
    if (GrayCount !== 8'h00) begin miscompares++; $display("FAIL rst_prio_gray got %h want 00", GrayCount); end
    vectors++;
    if (Wrapped !== 1'b0) begin miscompares++; $display("FAIL rst_prio_wrapped got %b want 0", Wrapped); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    Rst = 1'b1; En = 1'b0; Up = 1'b1; Load = 1'b0; LoadGray = 1'b0; LoadValue = 8'h00;
    rst4 = 1'b1; en4 = 1'b0; up4 = 1'b1; load4 = 1'b0; load_gray4 = 1'b0; load_value4 = 4'h0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_load_gray();
    test_load_bin();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
